// File: rtl/ann_backprop_update_pkg.sv
// ann_backprop_update_pkg: shared state encoding and default width for the backprop update block
package ann_backprop_update_pkg;
  localparam int DEFAULT_WIDTH = 32;
  typedef enum logic [3:0] {
    IDLE,
    S_X,
    S_Z,
    S_U,
    S_E,
    S_K,
    S_KA,
    S_KB,
    DONE
  } state_t;
endpackage

// File: rtl/ann_backprop_update_mul.sv
// ann_mul_unit: combinational signed multiplier keeping the low WIDTH bits of the product
module ann_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [WIDTH-1:0] p
);
  assign p = a * b;
endmodule

// File: rtl/ann_backprop_update.sv
// ann_backprop_update: multi-cycle forward recompute and gradient weight update using one shared multiplier
module ann_backprop_update
  import ann_backprop_update_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LR_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] w1_in,
  input  logic [WIDTH-1:0] w2_in,
  input  logic [WIDTH-1:0] w3_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] err_out,
  output logic [WIDTH-1:0] w1_new,
  output logic [WIDTH-1:0] w2_new,
  output logic [WIDTH-1:0] w3_new
);
  state_t state_q, state_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, t_q, t_d;
  logic signed [WIDTH-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic signed [WIDTH-1:0] x_q, x_d, g_q, g_d, u_q, u_d;
  logic signed [WIDTH-1:0] y_q, y_d, e_q, e_d, eg_q, eg_d;
  logic signed [WIDTH-1:0] k_q, k_d, ka_q, ka_d;
  logic signed [WIDTH-1:0] yo_q, yo_d, eo_q, eo_d;
  logic signed [WIDTH-1:0] w1n_q, w1n_d, w2n_q, w2n_d, w3n_q, w3n_d;
  logic signed [WIDTH-1:0] op_a, op_b, prod, y_now, e_now;

  assign y_now = u_q + g_q;
  assign e_now = t_q - y_now;

  ann_mul_unit #(.WIDTH(WIDTH)) u_mul (
    .a(op_a),
    .b(op_b),
    .p(prod)
  );

  // Operand select for the shared multiplier, decided purely by state; idle states feed zeros
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      S_X:     begin op_a = a_q;   op_b = w1_q;        end
      S_Z:     begin op_a = b_q;   op_b = w2_q;        end
      S_U:     begin op_a = g_q;   op_b = w3_q;        end
      S_E:     begin op_a = e_now; op_b = g_q;         end
      S_K:     begin op_a = e_q;   op_b = w3_q + 1'b1; end
      S_KA:    begin op_a = k_q;   op_b = a_q;         end
      S_KB:    begin op_a = k_q;   op_b = b_q;         end
      default: begin op_a = '0;    op_b = '0;          end
    endcase
  end

  // Next-state and datapath register updates, one product captured per state
  always_comb begin
    state_d = state_q;
    a_d = a_q; b_d = b_q; t_d = t_q;
    w1_d = w1_q; w2_d = w2_q; w3_d = w3_q;
    x_d = x_q; g_d = g_q; u_d = u_q;
    y_d = y_q; e_d = e_q; eg_d = eg_q;
    k_d = k_q; ka_d = ka_q;
    yo_d = yo_q; eo_d = eo_q;
    w1n_d = w1n_q; w2n_d = w2n_q; w3n_d = w3n_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a_in; b_d = b_in; t_d = target;
        w1_d = w1_in; w2_d = w2_in; w3_d = w3_in;
        state_d = S_X;
      end
      S_X: begin x_d = prod; state_d = S_Z; end
      S_Z: begin g_d = x_q + prod; state_d = S_U; end
      S_U: begin u_d = prod; state_d = S_E; end
      S_E: begin y_d = y_now; e_d = e_now; eg_d = prod; state_d = S_K; end
      S_K: begin k_d = prod; state_d = S_KA; end
      S_KA: begin ka_d = prod; state_d = S_KB; end
      S_KB: begin
        w1n_d = w1_q + (ka_q >>> LR_SHIFT);
        w2n_d = w2_q + (prod >>> LR_SHIFT);
        w3n_d = w3_q + (eg_q >>> LR_SHIFT);
        yo_d = y_q;
        eo_d = e_q;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0; b_q <= '0; t_q <= '0;
      w1_q <= '0; w2_q <= '0; w3_q <= '0;
      x_q <= '0; g_q <= '0; u_q <= '0;
      y_q <= '0; e_q <= '0; eg_q <= '0;
      k_q <= '0; ka_q <= '0;
      yo_q <= '0; eo_q <= '0;
      w1n_q <= '0; w2n_q <= '0; w3n_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; t_q <= t_d;
      w1_q <= w1_d; w2_q <= w2_d; w3_q <= w3_d;
      x_q <= x_d; g_q <= g_d; u_q <= u_d;
      y_q <= y_d; e_q <= e_d; eg_q <= eg_d;
      k_q <= k_d; ka_q <= ka_d;
      yo_q <= yo_d; eo_q <= eo_d;
      w1n_q <= w1n_d; w2n_q <= w2n_d; w3n_q <= w3n_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign y_out     = yo_q;
  assign err_out   = eo_q;
  assign w1_new    = w1n_q;
  assign w2_new    = w2n_q;
  assign w3_new    = w3n_q;
endmodule

// File: tb/tb_ann_backprop_update.sv
// tb_ann_backprop_update: directed checks of the backprop update block against a behavioural model
module tb_ann_backprop_update;
  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] a_in = '0, b_in = '0, target = '0, w1_in = '0, w2_in = '0, w3_in = '0;
  logic [W-1:0] y_out, err_out, w1_new, w2_new, w3_new;

  int total = 0;
  int bad = 0;
  bit exp_valid = 1'b0;
  logic signed [W-1:0] ex_y, ex_e, ex_w1, ex_w2, ex_w3;

  ann_backprop_update #(.WIDTH(W), .LR_SHIFT(S)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .target(target),
    .w1_in(w1_in), .w2_in(w2_in), .w3_in(w3_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .err_out(err_out),
    .w1_new(w1_new), .w2_new(w2_new), .w3_new(w3_new)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, $signed(act), $signed(exp));
    end
  endtask

  function automatic void model(input logic signed [W-1:0] a, b, t, w1, w2, w3,
                                output logic signed [W-1:0] y, e, n1, n2, n3);
    logic signed [W-1:0] g, k, p1, p2, p3;
    g  = a * w1 + b * w2;
    y  = g * w3 + g;
    e  = t - y;
    k  = e * (w3 + 1);
    p1 = k * a;
    p2 = k * b;
    p3 = e * g;
    n1 = w1 + (p1 >>> S);
    n2 = w2 + (p2 >>> S);
    n3 = w3 + (p3 >>> S);
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (!exp_valid) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid got=1 want=0");
      end else begin
        chk("y_out", y_out, ex_y);
        chk("err_out", err_out, ex_e);
        chk("w1_new", w1_new, ex_w1);
        chk("w2_new", w2_new, ex_w2);
        chk("w3_new", w3_new, ex_w3);
        chk("in_ready_in_done", {31'd0, in_ready}, '0);
      end
    end
  end

  task automatic issue(input logic signed [W-1:0] a, b, t, w1, w2, w3);
    int n;
    @(negedge clk);
    a_in = a; b_in = b; target = t; w1_in = w1; w2_in = w2; w3_in = w3;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    model(a, b, t, w1, w2, w3, ex_y, ex_e, ex_w1, ex_w2, ex_w3);
    exp_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic complete(input int hold);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 20);
    chk("latency", lat, 7);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("in_ready_held", {31'd0, in_ready}, '0);
      if (i == 1) begin
        a_in = 32'd99; target = 32'd12345; in_valid = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid_after_hs", {31'd0, out_valid}, '0);
    chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    exp_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic lit(input logic signed [W-1:0] y, e, n1, n2, n3);
    chk("lit_model_y", ex_y, y);
    chk("lit_model_e", ex_e, e);
    chk("lit_model_w1", ex_w1, n1);
    chk("lit_model_w2", ex_w2, n2);
    chk("lit_model_w3", ex_w3, n3);
    chk("lit_dut_y", y_out, y);
    chk("lit_dut_e", err_out, e);
    chk("lit_dut_w1", w1_new, n1);
    chk("lit_dut_w2", w2_new, n2);
    chk("lit_dut_w3", w3_new, n3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, '0);
    chk("rst_y", y_out, '0);
    chk("rst_w1", w1_new, '0);
    @(negedge clk);
    reset = 1'b0;

    issue(2, 3, 20, 1, 1, 1);
    complete(0);
    lit(10, 10, 3, 4, 4);

    issue(2, 3, 0, 1, 1, 1);
    complete(0);
    lit(10, -10, -2, -3, -3);

    issue(2, 3, 10, 1, 1, 1);
    complete(0);
    lit(10, 0, 1, 1, 1);

    issue(-3, 5, 7, 2, -1, 3);
    complete(5);
    repeat (3) @(negedge clk);
    chk("no_second_accept", {31'd0, in_ready}, 32'd1);

    issue(2, 3, 20, 1, 1, 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, '0);
    chk("midrst_y", y_out, '0);
    chk("midrst_e", err_out, '0);
    chk("midrst_w1", w1_new, '0);
    chk("midrst_w2", w2_new, '0);
    chk("midrst_w3", w3_new, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst_no_output", {31'd0, out_valid}, '0);

    issue(2, 3, 0, 1, 1, 1);
    complete(2);
    lit(10, -10, -2, -3, -3);

    issue(32'h0001_0000, 0, 0, 32'h0001_0000, 0, 0);
    complete(0);
    lit(0, 0, 32'h0001_0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
